// File: rtl/i2c_bus_monitor.sv
// Passive I2C observer: START/Sr/STOP detection, address capture and host read-NACK reporting.
// Optional SCL/SDA glitch filter enabled by defining I2C_BUS_MONITOR_GLITCH_FILTER_EN.
module i2c_bus_monitor #(
  parameter int unsigned FilterCycles = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       bus_start_o,
  output logic       bus_rstart_o,
  output logic       bus_stop_o,
  output logic       bus_busy_o,
  output logic [7:0] bus_addr_o,
  output logic       bus_addr_valid_o,
  output logic       host_nack_o
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StWait
  } state_e;

  state_e     state_q;
  logic       first_q;
  logic       scl_q, sda_q;
  logic       busy_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       scl_s, sda_s;
  logic       start_ev, stop_ev, rise_ev;

`ifdef I2C_BUS_MONITOR_GLITCH_FILTER_EN
  localparam logic [4:0] FiltLen = 5'(FilterCycles);

  logic       scl_f_q, sda_f_q;
  logic [3:0] scl_cnt_q, sda_cnt_q;

  // Each counter tracks consecutive raw samples that disagree with the filtered level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else if (!first_q) begin
      scl_f_q   <= scl_i;
      sda_f_q   <= sda_i;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      if (scl_i == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if ({1'b0, scl_cnt_q} + 5'd1 >= FiltLen) begin
        scl_f_q   <= scl_i;
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 4'd1;
      end
      if (sda_i == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if ({1'b0, sda_cnt_q} + 5'd1 >= FiltLen) begin
        sda_f_q   <= sda_i;
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 4'd1;
      end
    end
  end

  assign scl_s = scl_f_q;
  assign sda_s = sda_f_q;
`else
  assign scl_s = scl_i;
  assign sda_s = sda_i;
`endif

  // START/STOP require SCL high in both samples, so they never coincide with an SCL edge.
  assign start_ev = scl_q & scl_s & sda_q & ~sda_s;
  assign stop_ev  = scl_q & scl_s & ~sda_q & sda_s;
  assign rise_ev  = ~scl_q & scl_s;

  assign bus_busy_o = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      first_q          <= 1'b0;
      scl_q            <= 1'b1;
      sda_q            <= 1'b1;
      busy_q           <= 1'b0;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      bus_start_o      <= 1'b0;
      bus_rstart_o     <= 1'b0;
      bus_stop_o       <= 1'b0;
      bus_addr_o       <= 8'h00;
      bus_addr_valid_o <= 1'b0;
      host_nack_o      <= 1'b0;
    end else begin
      bus_start_o      <= 1'b0;
      bus_rstart_o     <= 1'b0;
      bus_stop_o       <= 1'b0;
      bus_addr_valid_o <= 1'b0;
      host_nack_o      <= 1'b0;
      if (!enable_i) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
        first_q <= 1'b0;
      end else if (!first_q) begin
        first_q <= 1'b1;
        scl_q   <= scl_i;
        sda_q   <= sda_i;
      end else begin
        scl_q <= scl_s;
        sda_q <= sda_s;
        if (start_ev) begin
          if (busy_q) begin
            bus_rstart_o <= 1'b1;
          end else begin
            bus_start_o <= 1'b1;
          end
          busy_q    <= 1'b1;
          state_q   <= StAddr;
          bit_cnt_q <= '0;
        end else if (stop_ev) begin
          bus_stop_o <= busy_q;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end else if (rise_ev) begin
          case (state_q)
            StAddr: begin
              if (bit_cnt_q == 3'd7) begin
                bus_addr_o       <= {shift_q, sda_s};
                bus_addr_valid_o <= 1'b1;
                state_q          <= StAddrAck;
              end else begin
                shift_q   <= {shift_q[5:0], sda_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
            StAddrAck: begin
              state_q   <= sda_s ? StWait : StData;
              bit_cnt_q <= '0;
            end
            StData: begin
              if (bit_cnt_q == 3'd7) begin
                state_q <= StDataAck;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
            StDataAck: begin
              if (sda_s) begin
                host_nack_o <= bus_addr_o[0];
                state_q     <= StWait;
              end else begin
                state_q   <= StData;
                bit_cnt_q <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
